// File: rtl/io_uart_pkg.sv
// Shared UART definitions: FSM state encoding and CPU status register layout.
// Meant to be imported by both the transmitter and a future receiver.
package io_uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam int STAT_EMPTY   = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_BUSY    = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 4;
  localparam int STAT_CNT_MSB = 6;

  function automatic logic [7:0] pack_status(input logic empty, input logic full,
                                             input logic busy, input logic ovf,
                                             input logic [2:0] cnt);
    logic [7:0] s;
    s = '0;
    s[STAT_EMPTY] = empty;
    s[STAT_FULL]  = full;
    s[STAT_BUSY]  = busy;
    s[STAT_OVF]   = ovf;
    s[STAT_CNT_MSB:STAT_CNT_LSB] = cnt;
    return s;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Generic synchronous FIFO, power-of-two depth; dout shows the head combinationally.
// No backpressure: push while full and pop while empty are ignored internally.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/io_uart_tx.sv
// 8N1 UART transmitter with transmit FIFO; txd falls one cycle after a push into an idle, empty block.
// No backpressure: writes to a full FIFO are dropped and flagged as sticky overflow in status.
module io_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       ovf_clr,
  output logic [7:0] status,
  output logic       txd
);
  import io_uart_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [7:0] BAUD_MAX = 8'(CLKS_PER_BIT - 1);

  logic          fifo_push;
  logic          fifo_pop;
  logic [7:0]    fifo_dout;
  logic          fifo_empty;
  logic          fifo_full;
  logic [CW-1:0] fifo_count;

  uart_state_e state_q, state_d;
  logic [7:0]  baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  sh_q, sh_d;
  logic        txd_q, txd_d;
  logic        ovf_q;
  logic        baud_end;

  assign fifo_push = wr_en && !fifo_full;

  uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .Clock (Clock),
    .Reset (Reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (wr_data),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  assign baud_end = (baud_q == BAUD_MAX);

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    sh_d     = sh_q;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          sh_d     = fifo_dout;
          state_d  = ST_START;
          baud_d   = '0;
          bit_d    = '0;
        end
      end
      ST_START: begin
        if (baud_end) begin
          state_d = ST_DATA;
          baud_d  = '0;
        end else begin
          baud_d = baud_q + 8'd1;
        end
      end
      ST_DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 3'd1;
            sh_d  = {1'b0, sh_q[7:1]};
          end
        end else begin
          baud_d = baud_q + 8'd1;
        end
      end
      ST_STOP: begin
        if (baud_end) begin
          state_d = ST_IDLE;
          baud_d  = '0;
        end else begin
          baud_d = baud_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // txd is registered from the next state so the line level lines up with the state.
    case (state_d)
      ST_START: txd_d = 1'b0;
      ST_DATA:  txd_d = sh_d[0];
      default:  txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      txd_q   <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      txd_q   <= txd_d;
      // A drop on this edge outranks a clear request.
      if (wr_en && fifo_full) ovf_q <= 1'b1;
      else if (ovf_clr)       ovf_q <= 1'b0;
    end
  end

  assign txd    = txd_q;
  assign status = pack_status(fifo_empty, fifo_full, (state_q != ST_IDLE), ovf_q,
                              3'(fifo_count));

endmodule

// File: tb/tb_io_uart_tx.sv
// Directed bench for io_uart_tx at CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_io_uart_tx;

  logic       Clock;
  logic       Reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       ovf_clr;
  logic [7:0] status;
  logic       txd;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  io_uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .ovf_clr (ovf_clr),
    .status  (status),
    .txd     (txd)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clock);
      #1;
      cyc++;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Samples each bit in its middle; ofs_in is the number of cycles already elapsed since the fall.
  task automatic decode(input int ofs_in, output logic [7:0] b);
    int ofs;
    int pos;
    ofs = ofs_in;
    b   = '0;
    for (int s = 0; s < 10; s++) begin
      pos = 2 + 4 * s;
      if (pos >= ofs) begin
        tick(pos - ofs);
        ofs = pos;
        if (s == 0)      chk("start_bit", {7'd0, txd}, 8'd0);
        else if (s == 9) chk("stop_bit", {7'd0, txd}, 8'd1);
        else             b[s-1] = txd;
      end
    end
  endtask

  task automatic rx_frame(output logic [7:0] b, output int fall);
    int n;
    n = 0;
    while (txd !== 1'b0 && n < 300) begin
      tick(1);
      n++;
    end
    chk("fall_seen", {7'd0, txd}, 8'd0);
    fall = cyc;
    decode(0, b);
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] exp_a5;
    int f0;
    int f1;

    Reset   = 1'b1;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    ovf_clr = 1'b0;
    tick(2);
    Reset = 1'b0;
    chk("reset_status", status, 8'h01);
    chk("reset_txd", {7'd0, txd}, 8'd1);
    tick(2);

    // Single byte 0xA5 from idle, checked every cycle of the frame.
    exp_a5 = 8'hA5;
    wr_en = 1'b1; wr_data = 8'hA5;
    tick(1);
    wr_en = 1'b0;
    chk("a5_txd_after_push", {7'd0, txd}, 8'd1);
    chk("a5_status_after_push", status, 8'h10);
    tick(1);
    chk("a5_status_busy", status, 8'h05);
    for (int i = 0; i < 40; i++) begin
      if (i < 4)       chk("a5_start", {7'd0, txd}, 8'd0);
      else if (i < 36) chk("a5_data", {7'd0, txd}, {7'd0, exp_a5[(i-4)/4]});
      else             chk("a5_stop", {7'd0, txd}, 8'd1);
      tick(1);
    end
    chk("a5_status_idle", status, 8'h01);
    chk("a5_txd_idle", {7'd0, txd}, 8'd1);

    // Five consecutive pushes, then overflow and its clear.
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = 8'h11 + 8'(i);
      tick(1);
    end
    chk("burst_full", status, 8'h46);
    wr_data = 8'h16;
    tick(1);
    chk("burst_overflow", status, 8'h4E);
    wr_data = 8'h17; ovf_clr = 1'b1;
    tick(1);
    chk("ovf_beats_clear", status, 8'h4E);
    wr_en = 1'b0;
    tick(1);
    ovf_clr = 1'b0;
    chk("ovf_cleared", status, 8'h46);
    decode(6, b);
    chk("burst_byte_11", b, 8'h11);
    for (int i = 0; i < 4; i++) begin
      rx_frame(b, f0);
      chk("burst_byte_queued", b, 8'h12 + 8'(i));
    end
    tick(2);
    chk("burst_drained", status, 8'h01);
    tick(50);
    chk("burst_no_extra", {7'd0, txd}, 8'd1);
    chk("burst_idle_status", status, 8'h01);

    // 0x00 then 0xFF; second push lands on the edge that pops the first.
    wr_en = 1'b1; wr_data = 8'h00;
    tick(1);
    wr_data = 8'hFF;
    tick(1);
    wr_en = 1'b0;
    chk("push_pop_count", status, 8'h14);
    rx_frame(b, f0);
    chk("pair_byte_00", b, 8'h00);
    rx_frame(b, f1);
    chk("pair_byte_ff", b, 8'hFF);
    chk("pair_spacing", 8'(f1 - f0), 8'd41);
    tick(2);
    chk("pair_idle", status, 8'h01);

    // Reset during data bit 3 with two bytes queued.
    wr_en = 1'b1; wr_data = 8'h30;
    tick(1);
    wr_data = 8'h5A;
    tick(1);
    wr_data = 8'h69;
    tick(1);
    wr_en = 1'b0;
    tick(16);
    chk("mid_frame_status", status, 8'h24);
    chk("mid_frame_bit3", {7'd0, txd}, 8'd0);
    Reset = 1'b1; wr_en = 1'b1; wr_data = 8'hEE; ovf_clr = 1'b1;
    tick(1);
    Reset = 1'b0; wr_en = 1'b0; ovf_clr = 1'b0;
    chk("abort_txd", {7'd0, txd}, 8'd1);
    chk("abort_status", status, 8'h01);
    for (int i = 0; i < 60; i++) begin
      tick(1);
      chk("abort_quiet", {7'd0, txd}, 8'd1);
    end
    chk("abort_final_status", status, 8'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
